// File: rtl/double_to_int_if.sv
// double_to_int_if: stb/ack streaming bundle between an operand producer and a result consumer
//   input_a / input_a_stb / input_a_ack    : binary64 operand channel
//   output_z / output_z_stb / output_z_ack : signed 64-bit result channel
//   master : producer/consumer side, slave : converter side
interface double_to_int_if;
   logic [63:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [63:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;
   modport master (output input_a, input_a_stb, output_z_ack, input input_a_ack, output_z, output_z_stb);
   modport slave (input input_a, input_a_stb, output_z_ack, output input_a_ack, output_z, output_z_stb);
endinterface

// File: rtl/double_to_int.sv
// double_to_int: iterative binary64 to signed 64-bit integer converter, truncating toward zero
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : double_to_int_if.slave, operand in (input_a*) and result out (output_z*)
//   DOUBLE_TO_INT_SATURATE_EN : when defined, overflow/Inf saturate by sign and NaN gives 0
module double_to_int (
   input  logic           clk,
   input  logic           rst,
   double_to_int_if.slave bus
);
   typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, CONVERT, PACK, PUT_Z} state_t;
   state_t      state_q, state_d;
   logic [63:0] a_q, a_d, m_q, m_d, z_q, z_d;
   logic [11:0] e_q, e_d;
   logic        s_q, s_d, ack_q, ack_d, stb_q, stb_d;
   logic        exp_all1, frac_z, e_neg, e_big, e_63, spec_hit;
   logic [63:0] ovf_val, spec_val;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= GET_A;
         a_q     <= '0;
         m_q     <= '0;
         z_q     <= '0;
         e_q     <= '0;
         s_q     <= 1'b0;
         ack_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         z_q     <= z_d;
         e_q     <= e_d;
         s_q     <= s_d;
         ack_q   <= ack_d;
         stb_q   <= stb_d;
      end
   end
   always_comb begin
      exp_all1 = a_q[62:52] == 11'h7ff;
      frac_z   = a_q[51:0] == 52'd0;
      e_neg    = e_q[11];
      e_big    = $signed(e_q) > 12'sd63;
      e_63     = e_q == 12'd63;
      spec_hit = exp_all1 | e_neg | e_big | (e_63 & ~(s_q & frac_z));
`ifdef DOUBLE_TO_INT_SATURATE_EN
      ovf_val  = (exp_all1 & ~frac_z) ? 64'd0 : s_q ? 64'h8000000000000000 : 64'h7fffffffffffffff;
`else
      ovf_val  = 64'h8000000000000000;
`endif
      spec_val = e_neg ? 64'd0 : ovf_val;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         GET_A:   state_d = (bus.input_a_stb & ack_q) ? UNPACK : GET_A;
         UNPACK:  state_d = SPECIAL;
         SPECIAL: state_d = spec_hit ? PACK : CONVERT;
         CONVERT: state_d = e_63 ? PACK : CONVERT;
         PACK:    state_d = PUT_Z;
         PUT_Z:   state_d = (bus.output_z_ack & stb_q) ? GET_A : PUT_Z;
         default: state_d = GET_A;
      endcase
   end
   // Special results are loaded into m with s cleared, so PACK emits them unchanged.
   always_comb begin
      a_d   = state_q == GET_A ? bus.input_a : a_q;
      s_d   = state_q == UNPACK ? a_q[63] : (state_q == SPECIAL && spec_hit) ? 1'b0 : s_q;
      e_d   = state_q == UNPACK ? {1'b0, a_q[62:52]} - 12'd1023 :
              (state_q == CONVERT && !e_63) ? e_q + 12'd1 : e_q;
      m_d   = state_q == UNPACK ? {1'b1, a_q[51:0], 11'b0} :
              (state_q == SPECIAL && spec_hit) ? spec_val :
              (state_q == CONVERT && !e_63) ? m_q >> 1 : m_q;
      z_d   = state_q == PACK ? (s_q ? ~m_q + 64'd1 : m_q) : z_q;
      ack_d = state_d == GET_A;
      stb_d = state_d == PUT_Z;
   end
   assign bus.input_a_ack  = ack_q;
   assign bus.output_z_stb = stb_q;
   assign bus.output_z     = z_q;
endmodule

// File: tb/tb_double_to_int.sv
// tb_double_to_int: directed and random checks of double_to_int against an arithmetic reference
module tb_double_to_int;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   double_to_int_if bus();
   double_to_int dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value = 1.frac * 2^(exp-1023), truncated; latency 67-e in range, else 3.
   function automatic void model(input logic [63:0] a, output logic [63:0] z, output int lat);
      int           ex, e;
      logic         s, nan;
      logic [127:0] mag;
      logic [63:0]  ovf;
      ex  = int'(a[62:52]);
      e   = ex - 1023;
      s   = a[63];
      nan = ex == 2047 && a[51:0] != 52'd0;
      ovf = 64'h8000000000000000;
`ifdef DOUBLE_TO_INT_SATURATE_EN
      ovf = nan ? 64'd0 : s ? 64'h8000000000000000 : 64'h7fffffffffffffff;
`endif
      lat = 3;
      if (ex == 2047) z = ovf;
      else if (e < 0) z = 64'd0;
      else if (e > 63) z = ovf;
      else begin
         mag = {75'd0, 1'b1, a[51:0]};
         mag = e >= 52 ? mag << (e - 52) : mag >> (52 - e);
         if (mag > 128'h8000000000000000 || (mag == 128'h8000000000000000 && !s)) z = ovf;
         else begin
            z   = s ? 64'd0 - mag[63:0] : mag[63:0];
            lat = 67 - e;
         end
      end
   endfunction

   // Called #1 after a rising edge with the converter idle.
   task automatic run(input logic [63:0] a, input int hold, input string tag);
      logic [63:0] z, held;
      int          lat, n;
      model(a, z, lat);
      bus.input_a     = a;
      bus.input_a_stb = 1'b1;
      n = 0;
      while (!bus.input_a_ack && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.input_a_stb = 1'b0;
      n = 0;
      while (!bus.output_z_stb && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " z"}, bus.output_z, z);
      held = bus.output_z;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold stb"}, 64'(bus.output_z_stb), 64'd1);
         chk({tag, " hold z"}, bus.output_z, held);
         chk({tag, " hold ack"}, 64'(bus.input_a_ack), 64'd0);
      end
      bus.output_z_ack = 1'b1;
      @(posedge clk); #1;
      bus.output_z_ack = 1'b0;
      chk({tag, " rearm ack"}, 64'(bus.input_a_ack), 64'd1);
      chk({tag, " rearm stb"}, 64'(bus.output_z_stb), 64'd0);
   endtask

   initial begin
      logic [63:0] r, a;
      int          ef;
      bus.input_a      = '0;
      bus.input_a_stb  = 1'b0;
      bus.output_z_ack = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset ack", 64'(bus.input_a_ack), 64'd0);
      chk("reset stb", 64'(bus.output_z_stb), 64'd0);
      chk("reset z", bus.output_z, 64'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      run(64'h3FF0000000000000, 0, "one");
      run(64'hC00C000000000000, 0, "neg3p5");
      run(64'h4330000000000001, 10, "2p52p1 backpressure");
      run(64'h3FE0000000000000, 0, "half");
      run(64'h8000000000000000, 0, "negzero");
      run(64'h0000000000000001, 0, "denormal");
      run(64'hBFECCCCCCCCCCCCD, 0, "neg0p9");
      run(64'hC3E0000000000000, 0, "min");
      run(64'h43E0000000000000, 0, "pow63");
      run(64'h7FF8000000000000, 0, "nan");
      run(64'h7FF0000000000000, 0, "posinf");
      run(64'hFFF0000000000000, 0, "neginf");
      run(64'hC3E0000000000001, 0, "negovf");
      run(64'h43DFFFFFFFFFFFFF, 0, "maxpos");
      run(64'h4059000000000000, 0, "hundred");
      // Reset mid-CONVERT while converting 1.0
      bus.input_a     = 64'h3FF0000000000000;
      bus.input_a_stb = 1'b1;
      @(posedge clk); #1;
      bus.input_a_stb = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midreset stb", 64'(bus.output_z_stb), 64'd0);
      chk("midreset ack", 64'(bus.input_a_ack), 64'd0);
      chk("midreset z", bus.output_z, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(64'h4059000000000000, 0, "after reset");
      for (int k = 0; k < 40; k++) begin
         r  = {$urandom, $urandom};
         ef = int'($urandom_range(1023 + 66, 1023 - 3));
         a  = {r[63], 11'(ef), r[51:0]};
         run(a, k % 3, "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
